// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder_if
//  Description : Request/response bundle between the MEM stage and the
//                data-memory responder (two independent valid/ready channels).
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_responder_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic [3:0]  reqByteEnable;
    logic        respValid;
    logic        respReady;
    logic [31:0] respReadData;
    logic        respError;

    modport master (
        output reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, respReady,
        input  reqReady, respValid, respReadData, respError
    );

    modport slave (
        input  reqValid, reqWrite, reqAddress, reqWriteData, reqByteEnable, respReady,
        output reqReady, respValid, respReadData, respError
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Fixed-latency data-memory responder servicing one load/store
//                at a time with byte enables, alignment and range checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  wire logic               clock,
    input  wire logic               reset,
    data_memory_responder_if.slave  bus
);

    localparam int         c_INDEX_BITS = $clog2(DEPTH);
    localparam logic [3:0] c_COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                    r_write;
    logic [31:0]             r_address;
    logic [31:0]             r_write_data;
    logic [3:0]              r_byte_enable;
    logic [3:0]              r_count;
    logic [31:0]             r_read_data;
    logic                    r_error;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_ready;
    logic                    w_valid;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_op_write;
    logic [31:0]             w_op_address;
    logic [31:0]             w_op_data;
    logic [3:0]              w_op_be;
    logic [c_INDEX_BITS-1:0] w_index;
    logic                    w_error;
    logic                    w_commit;
    logic [31:0]             w_merged;

    // ------------------------------------------------------------------------
    // Control FSM; handshake outputs decode only the state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.reqValid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_complete   = 1'b1;
                        w_state_next = RESPOND;
                    end else begin
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_count == 4'd0) begin
                    w_complete   = 1'b1;
                    w_state_next = RESPOND;
                end
            end
            RESPOND: begin
                w_valid = 1'b1;
                if (bus.respReady) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.reqReady     = w_ready;
    assign bus.respValid    = w_valid;
    assign bus.respReadData = r_read_data;
    assign bus.respError    = r_error;

    // With single-cycle latency the access completes on the acceptance edge,
    // so the operands come straight from the bus instead of the latches.
    assign w_op_write   = (r_state == IDLE) ? bus.reqWrite      : r_write;
    assign w_op_address = (r_state == IDLE) ? bus.reqAddress    : r_address;
    assign w_op_data    = (r_state == IDLE) ? bus.reqWriteData  : r_write_data;
    assign w_op_be      = (r_state == IDLE) ? bus.reqByteEnable : r_byte_enable;

    assign w_index  = w_op_address[c_INDEX_BITS+1:2];
    assign w_error  = (w_op_address[1:0] != 2'b00) ||
                      (w_op_address[31:c_INDEX_BITS+2] != '0);
    assign w_commit = w_complete && w_op_write && !w_error;

    // ------------------------------------------------------------------------
    // Request latch and latency counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_write       <= 1'b0;
            r_address     <= '0;
            r_write_data  <= '0;
            r_byte_enable <= '0;
            r_count       <= '0;
        end else if (w_accept) begin
            r_write       <= bus.reqWrite;
            r_address     <= bus.reqAddress;
            r_write_data  <= bus.reqWriteData;
            r_byte_enable <= bus.reqByteEnable;
            r_count       <= c_COUNT_LOAD;
        end else if ((r_state == BUSY) && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Response registers: captured at completion, cleared when consumed
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_read_data <= '0;
            r_error     <= 1'b0;
        end else if (w_complete) begin
            r_read_data <= (w_op_write || w_error) ? 32'h0 : r_mem[w_index];
            r_error     <= w_error;
        end else if ((r_state == RESPOND) && bus.respReady) begin
            r_read_data <= '0;
            r_error     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Word storage with per-lane merge of the store data
    // ------------------------------------------------------------------------
    always_comb begin
        w_merged = r_mem[w_index];
        for (int b = 0; b < 4; b++) begin
            if (w_op_be[b]) begin
                w_merged[8*b +: 8] = w_op_data[8*b +: 8];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_mem[g] <= '0;
            end else if (w_commit && (w_index == c_INDEX_BITS'(g))) begin
                r_mem[g] <= w_merged;
            end
        end
    end

endmodule
`default_nettype wire
